// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared definitions for the RF link sequencer.
//   seq_state_t  - sequencer FSM states
//   MODE_*       - {M1,M0} mode constants
//   SYNC_STAGES  - depth of the AUX synchroniser
package rf_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_MODE_SET,
    ST_MODE_WAIT_LOW
  } seq_state_t;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_CONFIG = 2'b11;
  localparam int         SYNC_STAGES = 2;
endpackage

// File: rtl/rf_sync_fifo.sv
// rf_sync_fifo: single-clock outbound byte buffer.
//   push/wdata   - enqueue; silently dropped while full
//   pop/rdata    - dequeue; rdata is the current head (show-ahead)
//   full/empty/level - registered occupancy status
module rf_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  internal_clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    level
);
  localparam int LW = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic                  do_push, do_pop;
  logic [PTR_WIDTH:0]    level_nxt;

  // full is the registered flag, so a write at full is dropped even if
  // the same edge pops.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign level_nxt = level + LW'(do_push) - LW'(do_pop);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge internal_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/rf_link_sequencer.sv
// rf_link_sequencer: MCU-side sequencer feeding com_uart and the M0/M1 pins.
//   wr_data/wr_en        - enqueue outbound byte; full/level report buffer state
//   mode_req/_valid      - request {M1,M0}; mode_req_ready low while one is pending
//   mode_ack             - pulse in the first cycle the new M0/M1 are driven
//   AUX                  - async transceiver status, synchronised internally
//   data_bus_in_uart/TX_use - byte and 1-cycle strobe to com_uart
//   busy                 - FSM not idle or buffer non-empty
//   timeout              - pulse when an AUX wait overruns TIMEOUT_CYCLES
module rf_link_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 16,
  parameter int PTR_WIDTH         = 4,
  parameter int GAP_CYCLES        = 2,
  parameter int AUX_SETTLE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES    = 100000,
  parameter int CNT_WIDTH         = 17
) (
  input  logic                  internal_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic [PTR_WIDTH:0]    level,
  input  logic [1:0]            mode_req,
  input  logic                  mode_req_valid,
  output logic                  mode_req_ready,
  output logic                  mode_ack,
  input  logic                  AUX,
  output logic                  M0,
  output logic                  M1,
  output logic [DATA_WIDTH-1:0] data_bus_in_uart,
  output logic                  TX_use,
  output logic                  busy,
  output logic                  timeout
);
  localparam int LW    = PTR_WIDTH + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t             state;
  logic [SYNC_STAGES-1:0] aux_sync;
  logic                   aux_s, aux_ready;
  logic [CNT_WIDTH-1:0]   settle_cnt, to_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [PTR_WIDTH:0]     drain_cnt, level_nxt;
  logic [1:0]             pend_mode;
  logic                   pending, mode_take;
  logic                   fifo_empty, pop, start_mode;
  logic                   to_run, to_hit, wait_low_exit;
  logic [DATA_WIDTH-1:0]  head;

  rf_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_fifo (
    .internal_clk (internal_clk),
    .rst_n        (rst_n),
    .push         (wr_en),
    .wdata        (wr_data),
    .pop          (pop),
    .rdata        (head),
    .full         (full),
    .empty        (fifo_empty),
    .level        (level)
  );

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) aux_sync <= '0;
    else        aux_sync <= {aux_sync[SYNC_STAGES-2:0], AUX};
  end
  assign aux_s = aux_sync[SYNC_STAGES-1];

  // Saturating count of consecutive high aux_s cycles.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n)          settle_cnt <= '0;
    else if (!aux_s)     settle_cnt <= '0;
    else if (!aux_ready) settle_cnt <= settle_cnt + 1'b1;
  end
  assign aux_ready = (settle_cnt >= CNT_WIDTH'(AUX_SETTLE_CYCLES));

  assign pending   = !mode_req_ready;
  assign mode_take = mode_req_valid && mode_req_ready;
  // drain_cnt counts bytes queued ahead of the pending mode change; a
  // pending mode with nothing left ahead of it blocks further data.
  assign start_mode = (state == ST_IDLE) && pending && (drain_cnt == '0) && aux_ready;
  assign pop        = (state == ST_IDLE) && !fifo_empty && aux_ready &&
                      (!pending || (drain_cnt != '0));
  // Snapshot includes a same-cycle write and a same-cycle pop.
  assign level_nxt  = level + LW'(wr_en && !full) - LW'(pop);

  assign to_run = (state == ST_MODE_WAIT_LOW) ||
                  ((state == ST_IDLE) && (!fifo_empty || pending) && !aux_ready);
  assign to_hit = to_run && (to_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign wait_low_exit = (state == ST_MODE_WAIT_LOW) && !aux_s;

  assign busy = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      gap_cnt          <= '0;
      to_cnt           <= '0;
      drain_cnt        <= '0;
      pend_mode        <= MODE_NORMAL;
      mode_req_ready   <= 1'b1;
      {M1, M0}         <= MODE_NORMAL;
      data_bus_in_uart <= '0;
      TX_use           <= 1'b0;
      mode_ack         <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      TX_use   <= 1'b0;
      mode_ack <= 1'b0;
      timeout  <= to_hit;
      // Restart on each overrun and whenever the wait condition changes.
      to_cnt   <= (!to_run || to_hit || wait_low_exit) ? '0 : to_cnt + 1'b1;

      if (mode_take) begin
        pend_mode      <= mode_req;
        mode_req_ready <= 1'b0;
        drain_cnt      <= level_nxt;
      end else if (pop && pending) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_mode) begin
            state <= ST_MODE_SET;
          end else if (pop) begin
            // Strobe is launched on entry so it is high exactly while in SEND.
            state            <= ST_SEND;
            TX_use           <= 1'b1;
            data_bus_in_uart <= head;
          end
        end
        ST_SEND: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else                                   gap_cnt <= gap_cnt + 1'b1;
        end
        ST_MODE_SET: begin
          {M1, M0}       <= pend_mode;
          mode_ack       <= 1'b1;
          mode_req_ready <= 1'b1;
          state          <= ST_MODE_WAIT_LOW;
        end
        ST_MODE_WAIT_LOW: begin
          if (!aux_s || to_hit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_link_sequencer.sv
// tb_rf_link_sequencer: directed + randomized bench for rf_link_sequencer.
// Expected traffic is an ordered list of events (byte sent / mode applied)
// built from the writes and mode requests the bench issues; timing is
// checked against the latency/spacing rules of the link.
module tb_rf_link_sequencer;
  import rf_seq_pkg::*;

  localparam int DW = 8, DEPTH = 16, PW = 4, GAP = 2, SETTLE = 10, TMO = 200, CW = 9;

  logic            internal_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_en = 1'b0;
  logic            full;
  logic [PW:0]     level;
  logic [1:0]      mode_req = '0;
  logic            mode_req_valid = 1'b0;
  logic            mode_req_ready, mode_ack;
  logic            AUX = 1'b1;
  logic            M0, M1;
  logic [DW-1:0]   data_bus_in_uart;
  logic            TX_use, busy, timeout;

  rf_link_sequencer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW), .GAP_CYCLES(GAP),
    .AUX_SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .internal_clk(internal_clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .level(level), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready), .mode_ack(mode_ack), .AUX(AUX), .M0(M0), .M1(M1),
    .data_bus_in_uart(data_bus_in_uart), .TX_use(TX_use), .busy(busy), .timeout(timeout)
  );

  always #5 internal_clk = ~internal_clk;

  int cyc = 0;
  always @(posedge internal_clk) cyc <= cyc + 1;

  typedef struct packed { logic kind; logic [DW-1:0] val; } ev_t; // kind 0 = byte, 1 = mode

  ev_t obs[$];
  int  obs_t[$];
  int  to_t[$];
  ev_t exp_q[$];

  always @(negedge internal_clk) begin
    if (TX_use) begin
      obs.push_back(ev_t'{kind: 1'b0, val: data_bus_in_uart});
      obs_t.push_back(cyc);
    end
    if (mode_ack) begin
      obs.push_back(ev_t'{kind: 1'b1, val: DW'({M1, M0})});
      obs_t.push_back(cyc);
    end
    if (timeout) to_t.push_back(cyc);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge internal_clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, obs.size() >= n, 1);
  endtask

  task automatic compare_seq(input string tag, input int b);
    chk({tag, "_count"}, obs.size() - b, exp_q.size());
    for (int i = 0; i < exp_q.size() && b + i < obs.size(); i++)
      chk(tag, obs[b + i], exp_q[i]);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {M1, M0, TX_use, mode_ack, timeout, full, busy, mode_req_ready}, 8'b0000_0001);
    chk({tag, "_bus"}, data_bus_in_uart, 0);
    chk({tag, "_level"}, level, 0);
  endtask

  logic [DW-1:0] burst [8] = '{8'h27, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

  initial begin
    int b, b2, w0, rc, tb0, k, resp, nwr;
    logic [DW-1:0] v;
    logic [1:0] m;

    // ---- reset values
    repeat (3) @(posedge internal_clk);
    #2;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    step(SETTLE + 5);

    // ---- settled burst: order, first latency, spacing
    exp_q.delete();
    b = obs.size();
    for (int i = 0; i < 8; i++) begin
      put(burst[i]);
      if (i == 0) w0 = cyc;
      exp_q.push_back(ev_t'{kind: 1'b0, val: burst[i]});
    end
    wait_obs(b + 8, 100, "burst_done");
    compare_seq("burst", b);
    // written at edge w0 -> strobe in the cycle after the next edge
    if (obs.size() > b) chk("burst_lat", obs_t[b] - w0, 1);
    for (int i = 1; i < 8 && b + i < obs.size(); i++)
      chk("burst_gap", obs_t[b + i] - obs_t[b + i - 1], GAP + 2);
    step(10);

    // ---- AUX low holds data; raise -> sync + settle + 1 cycles
    AUX = 1'b0;
    step(5);
    exp_q.delete();
    b = obs.size();
    for (int i = 0; i < 3; i++) begin
      v = DW'($urandom);
      put(v);
      exp_q.push_back(ev_t'{kind: 1'b0, val: v});
    end
    step(30);
    chk("auxlo_hold", obs.size() - b, 0);
    chk("auxlo_busy", busy, 1);
    AUX = 1'b1;
    rc = cyc;
    wait_obs(b + 1, 100, "auxlo_first");
    if (obs.size() > b) chk("auxlo_lat", obs_t[b] - rc, SETTLE + 3);
    wait_obs(b + 3, 100, "auxlo_done");
    compare_seq("auxlo", b);
    step(10);

    // ---- mode change ordered behind queued bytes
    exp_q.delete();
    b = obs.size();
    for (int i = 0; i < 2; i++) begin
      v = DW'($urandom);
      put(v);
      exp_q.push_back(ev_t'{kind: 1'b0, val: v});
    end
    mode_req = MODE_CONFIG;
    mode_req_valid = 1'b1;
    step();
    exp_q.push_back(ev_t'{kind: 1'b1, val: DW'(MODE_CONFIG)});
    chk("mreq_ready_lo", mode_req_ready, 0);
    // second request while pending must be ignored
    mode_req = 2'b01;
    v = DW'($urandom);
    put(v);
    mode_req_valid = 1'b0;
    exp_q.push_back(ev_t'{kind: 1'b0, val: v});
    wait_obs(b + 3, 100, "mode_ack_seen");
    step(5);
    chk("mode_wait_hold", obs.size() - b, 3);
    chk("mode_pins", {M1, M0}, 2'b11);
    AUX = 1'b0;
    step(5);
    AUX = 1'b1;
    rc = cyc;
    wait_obs(b + 4, 100, "mode_done");
    if (obs.size() > b + 3) chk("mode_relat", obs_t[b + 3] - rc, SETTLE + 3);
    compare_seq("mode", b);
    chk("mreq_ready_hi", mode_req_ready, 1);
    step(SETTLE + 5);

    // ---- AUX never drops after mode set -> timeout back to idle
    exp_q.delete();
    b = obs.size();
    tb0 = to_t.size();
    mode_req = 2'b01;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    exp_q.push_back(ev_t'{kind: 1'b1, val: DW'(2'b01)});
    wait_obs(b + 1, 20, "tmo_ack");
    k = 0;
    while (to_t.size() == tb0 && k < TMO + 20) begin
      step();
      k++;
    end
    chk("tmo_seen", to_t.size() > tb0, 1);
    if (to_t.size() > tb0 && obs.size() > b) chk("tmo_delay", to_t[tb0] - obs_t[b], TMO);
    chk("tmo_idle", busy, 0);
    chk("tmo_pins", {M1, M0}, 2'b01);
    compare_seq("tmo", b);
    step(TMO + 10);
    chk("tmo_once", to_t.size() - tb0, 1);

    // ---- asynchronous reset mid-burst with a pending mode
    b = obs.size();
    for (int i = 0; i < 6; i++) put(DW'($urandom));
    mode_req = MODE_CONFIG;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    wait_obs(b + 1, 50, "arst_started");
    @(negedge internal_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    step(2);
    rst_n = 1'b1;
    b2 = obs.size();
    step(SETTLE + 30);
    chk("arst_no_tx", obs.size() - b2, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", mode_req_ready, 1);

    // ---- overflow: DEPTH+1 writes, then write coincident with first pop
    AUX = 1'b0;
    step(5);
    exp_q.delete();
    b = obs.size();
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = DW'($urandom);
      put(v);
      if (i < DEPTH) exp_q.push_back(ev_t'{kind: 1'b0, val: v});
    end
    chk("full_flag", full, 1);
    chk("full_level", level, DEPTH);
    AUX = 1'b1;
    rc = cyc;
    step(SETTLE + 2);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("full_popwr_level", level, DEPTH - 1);
    chk("full_popwr_full", full, 0);
    wait_obs(b + DEPTH, DEPTH * (GAP + 2) + 50, "full_done");
    if (obs.size() > b) chk("full_lat", obs_t[b] - rc, SETTLE + 3);
    step(10);
    compare_seq("full", b);

    // ---- randomized traffic with interleaved mode changes
    step(SETTLE + 5);
    exp_q.delete();
    b = obs.size();
    resp = 0;
    nwr = 0;
    for (int c = 0; c < 2000; c++) begin
      if (resp > 0) begin
        resp--;
        if (resp == 3) AUX = 1'b0;
        else if (resp == 0) AUX = 1'b1;
      end else if (mode_ack) begin
        resp = 8;
      end
      wr_en = 1'b0;
      mode_req_valid = 1'b0;
      if (c < 300) begin
        if (!full && nwr < 40 && $urandom_range(0, 2) == 0) begin
          v = DW'($urandom);
          wr_en = 1'b1;
          wr_data = v;
          exp_q.push_back(ev_t'{kind: 1'b0, val: v});
          nwr++;
        end
        if (mode_req_ready && $urandom_range(0, 31) == 0) begin
          m = 2'($urandom_range(0, 3));
          mode_req = m;
          mode_req_valid = 1'b1;
          exp_q.push_back(ev_t'{kind: 1'b1, val: DW'(m)});
        end
      end else if (resp == 0 && obs.size() - b == exp_q.size() && !busy) begin
        break;
      end
      step();
    end
    wr_en = 1'b0;
    mode_req_valid = 1'b0;
    AUX = 1'b1;
    compare_seq("rnd", b);
    for (int i = b + 1; i < obs.size(); i++)
      if (obs[i].kind == 1'b0 && obs[i - 1].kind == 1'b0)
        chk("rnd_space", (obs_t[i] - obs_t[i - 1]) >= GAP + 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
